// File: rtl/traffic_pkg.sv
// Lamp and phase encodings plus default dwell constants for the phase scheduler.
// The PW phase is only reachable in builds that define PED_WALK_EN.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    // state | meaning
    // HG    | highway green, waiting for demand and minimum dwell
    // HY    | highway yellow
    // AR1   | all-red clearance before the country road
    // CG    | country green, capped dwell
    // CY    | country yellow
    // AR2   | all-red clearance before highway or walk
    // PW    | pedestrian walk, both roads red
    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6
    } state_t;

    localparam int DEF_TW       = 4;
    localparam int DEF_MIN_HG   = 8;
    localparam int DEF_YEL      = 3;
    localparam int DEF_ALLRED   = 1;
    localparam int DEF_MAX_CG   = 6;
    localparam int DEF_PED_TIME = 4;

    // Unknown codes decode like HG so the lamps fall back to the safe pattern.
    function automatic lamp_t hwy_of(input state_t s);
        case (s)
            HY:                    hwy_of = YELLOW;
            AR1, CG, CY, AR2, PW:  hwy_of = RED;
            default:               hwy_of = GREEN;
        endcase
    endfunction

    function automatic lamp_t cntry_of(input state_t s);
        case (s)
            CG:      cntry_of = GREEN;
            CY:      cntry_of = YELLOW;
            default: cntry_of = RED;
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the phase scheduler: synchronous clear, otherwise counts up and
// holds at all-ones. Identical in PED_WALK_EN and default builds.
module dwell_timer #(
    parameter int TW = 4
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic          clr,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != {TW{1'b1}}) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed highway/country intersection sequencer with registered lamp outputs.
// Define PED_WALK_EN to add the ped_req/walk ports and the pedestrian walk phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW       = DEF_TW,
    parameter int MIN_HG   = DEF_MIN_HG,
    parameter int YEL      = DEF_YEL,
    parameter int ALLRED   = DEF_ALLRED,
    parameter int MAX_CG   = DEF_MAX_CG,
    parameter int PED_TIME = DEF_PED_TIME
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       x,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase
);

    state_t        state_q;
    state_t        state_d;
    lamp_t         hwy_q;
    lamp_t         hwy_d;
    lamp_t         cntry_q;
    lamp_t         cntry_d;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          ped_pend;

    logic hg_min_done;
    logic yel_done;
    logic allred_done;
    logic cg_cap_done;
    logic walk_done;

    dwell_timer #(
        .TW(TW)
    ) u_dwell_timer (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (timer_clr),
        .count   (timer)
    );

    // A dwell of D cycles ends on the cycle where the timer reads D-1.
    assign hg_min_done = (timer >= TW'(MIN_HG - 1));
    assign yel_done    = (timer == TW'(YEL - 1));
    assign allred_done = (timer == TW'(ALLRED - 1));
    assign cg_cap_done = (timer == TW'(MAX_CG - 1));
    assign walk_done   = (timer == TW'(PED_TIME - 1));

`ifdef PED_WALK_EN
    logic ped_pend_q;
    logic ped_pend_d;
    logic walk_q;
    logic walk_d;

    assign ped_pend = ped_pend_q;
`else
    assign ped_pend = 1'b0;
`endif

    always_comb begin
        state_d = HG;
        case (state_q)
            HG: begin
                if ((x || ped_pend) && hg_min_done) state_d = HY;
                else                                state_d = HG;
            end
            HY: begin
                if (yel_done) state_d = AR1;
                else          state_d = HY;
            end
            AR1: begin
                if (allred_done) state_d = x ? CG : AR2;
                else             state_d = AR1;
            end
            CG: begin
                if (!x || cg_cap_done) state_d = CY;
                else                   state_d = CG;
            end
            CY: begin
                if (yel_done) state_d = AR2;
                else          state_d = CY;
            end
            AR2: begin
                if (allred_done) state_d = ped_pend ? PW : HG;
                else             state_d = AR2;
            end
            PW: begin
                if (walk_done) state_d = HG;
                else           state_d = PW;
            end
            default: state_d = HG;
        endcase
    end

    assign timer_clr = (state_d != state_q);
    assign hwy_d     = hwy_of(state_d);
    assign cntry_d   = cntry_of(state_d);

`ifdef PED_WALK_EN
    // A request arriving on the PW-entry edge outranks the clear and is kept.
    assign ped_pend_d = ped_req || (ped_pend_q && !((state_d == PW) && (state_q != PW)));
    assign walk_d     = (state_d == PW);
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= HG;
            hwy_q      <= GREEN;
            cntry_q    <= RED;
`ifdef PED_WALK_EN
            walk_q     <= 1'b0;
            ped_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hwy_q      <= hwy_d;
            cntry_q    <= cntry_d;
`ifdef PED_WALK_EN
            walk_q     <= walk_d;
            ped_pend_q <= ped_pend_d;
`endif
        end
    end

    assign hwy   = hwy_q;
    assign cntry = cntry_q;
    assign phase = state_q;
`ifdef PED_WALK_EN
    assign walk  = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected phase segments are queued by
// the stimulus and compared by a monitor; PED_WALK_EN enables the walk scenarios.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_HG  = 3'd0;
    localparam logic [2:0] P_HY  = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_CG  = 3'd3;
    localparam logic [2:0] P_CY  = 3'd4;
    localparam logic [2:0] P_AR2 = 3'd5;
    localparam logic [2:0] P_PW  = 3'd6;

    logic       clock   = 1'b0;
    logic       clear_n = 1'b1;
    logic       x       = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;
    logic       walk_obs;

`ifdef PED_WALK_EN
    logic ped_req = 1'b0;
    logic walk;
    assign walk_obs = walk;
`else
    assign walk_obs = 1'b0;
`endif

    traffic_phase_scheduler dut (
        .clock   (clock),
        .clear_n (clear_n),
        .x       (x),
`ifdef PED_WALK_EN
        .ped_req (ped_req),
        .walk    (walk),
`endif
        .hwy     (hwy),
        .cntry   (cntry),
        .phase   (phase)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] len;
        logic [1:0] h;
        logic [1:0] c;
        logic       w;
    } seg_t;

    seg_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;
    string test_name = "init";

    task automatic chk(input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d, expected %0d", test_name, what, act, exp);
        end
    endtask

    // Lamp pattern each phase must show, straight from the lamp table.
    task automatic push(input logic [2:0] ph, input int len);
        seg_t s;
        s.ph  = ph;
        s.len = 8'(len);
        s.h   = 2'd0;
        s.c   = 2'd0;
        s.w   = 1'b0;
        case (ph)
            P_HG:    s.h = 2'd2;
            P_HY:    s.h = 2'd1;
            P_CG:    s.c = 2'd2;
            P_CY:    s.c = 2'd1;
            P_PW:    s.w = 1'b1;
            default: ;
        endcase
        exp_q.push_back(s);
    endtask

    task automatic monitor();
        seg_t cur;
        seg_t e;
        int   len;
        len = 0;
        cur = '0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                checks++;
                assert (hwy == 2'd0 || cntry == 2'd0)
                else begin
                    errors++;
                    $display("FAIL %s/lamp_conflict: hwy=%0d cntry=%0d, required one red", test_name, hwy, cntry);
                end
            end
            if (!mon_en) begin
                len = 0;
            end else if (len == 0) begin
                cur = {phase, 8'd1, hwy, cntry, walk_obs};
                len = 1;
            end else if (phase == cur.ph) begin
                len++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/extra_segment: phase %0d for %0d cycles, none expected", test_name, cur.ph, len);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("phase_of_seg"), int'(cur.ph), int'(e.ph));
                    chk($sformatf("dwell_of_phase%0d", e.ph), len, int'(e.len));
                    chk($sformatf("lamps_of_phase%0d", e.ph), int'({cur.h, cur.c, cur.w}), int'({e.h, e.c, e.w}));
                end
                cur = {phase, 8'd1, hwy, cntry, walk_obs};
                len = 1;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Reset is checked before any clock edge can move the state.
    task automatic do_reset();
        step(1);
        mon_en  = 1'b0;
        clear_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_phase", int'(phase), int'(P_HG));
        chk("reset_hwy", int'(hwy), 2);
        chk("reset_cntry", int'(cntry), 0);
        chk("reset_walk", int'(walk_obs), 0);
        step(1);
        clear_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic wait_phase(input logic [2:0] ph, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (phase == ph) break;
            step(1);
        end
        chk($sformatf("reach_phase%0d", ph), int'(phase), int'(ph));
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        chk("pending_segments", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        test_name = "reset_mid_cg";
        x = 1'b1;
        do_reset();
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1);
        wait_phase(P_CG, 40);
        step(2);
        chk("cg_lamp_before_reset", int'(cntry), 2);
        wait_drain(5);
        do_reset();

        test_name = "x_held_cap";
        x = 1'b1;
        do_reset();
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1);
        push(P_CG, 6); push(P_CY, 3); push(P_AR2, 1);
        wait_drain(60);

        test_name = "x_drop_in_cg";
        x = 1'b1;
        do_reset();
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1);
        push(P_CG, 2); push(P_CY, 3); push(P_AR2, 1);
        wait_phase(P_CG, 40);
        step(1);
        x = 1'b0;
        wait_drain(40);

        test_name = "x_pulse_then_hold";
        x = 1'b0;
        do_reset();
        step(3);
        x = 1'b1;
        step(1);
        x = 1'b0;
        step(3);
        x = 1'b1;
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1);
        push(P_CG, 6); push(P_CY, 3); push(P_AR2, 1);
        wait_drain(60);

        test_name = "x_drop_in_hy";
        x = 1'b1;
        do_reset();
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1); push(P_AR2, 1);
        wait_phase(P_HY, 20);
        x = 1'b0;
        wait_drain(30);
        step(20);
        chk("hg_hold_no_demand", int'(phase), int'(P_HG));

`ifdef PED_WALK_EN
        test_name = "ped_only";
        x = 1'b0;
        do_reset();
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1); push(P_AR2, 1); push(P_PW, 4);
        wait_drain(40);

        test_name = "ped_with_x_and_rerequest";
        x = 1'b1;
        do_reset();
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1); push(P_CG, 6);
        push(P_CY, 3); push(P_AR2, 1); push(P_PW, 4);
        push(P_HG, 8); push(P_HY, 3); push(P_AR1, 1); push(P_AR2, 1); push(P_PW, 4);
        wait_phase(P_AR2, 60);
        ped_req = 1'b1;
        x = 1'b0;
        step(1);
        ped_req = 1'b0;
        wait_drain(80);
        step(20);
        chk("hg_hold_after_walk", int'(phase), int'(P_HG));
`endif

        mon_en = 1'b0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
